// File: rtl/amp_result_collector.sv
// Result collector: captures amplifier beats into a first-word-fall-through FIFO with drop counting.
// Optional sequence checker on the 'no' field, enabled by AMP_COLLECT_SEQ_CHECK_EN.
module amp_result_collector #(
   parameter int NO_WIDTH  = 8,
   parameter int RES_WIDTH = 16,
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          clr_i,
   input  logic                          rd_val_i,
   input  logic [NO_WIDTH+RES_WIDTH-1:0] rd_data_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [NO_WIDTH-1:0]           out_no_o,
   output logic [RES_WIDTH-1:0]          out_res_o,
   output logic [$clog2(DEPTH):0]        level_o,
   output logic                          overflow_o,
   output logic [CNT_WIDTH-1:0]          drop_cnt_o,
   output logic                          seq_err_o,
   output logic [CNT_WIDTH-1:0]          seq_err_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int W  = NO_WIDTH + RES_WIDTH;

   logic [W-1:0]         mem [DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr, level;
   logic                 full, empty, pop, push, drop;
   logic [W-1:0]         head;
   logic                 overflow;
   logic [CNT_WIDTH-1:0] drop_cnt;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign level = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && out_ready_i;
   assign push  = rd_val_i && (!full || pop);
   assign drop  = rd_val_i && full && !pop;

   always_ff @(posedge clk_i) begin
      if (push && !clr_i) mem[wr_ptr[AW-1:0]] <= rd_data_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (clr_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   // Head is forced to zero when empty so stale entries never leak out.
   assign head        = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign out_valid_o = !empty;
   assign out_no_o    = head[W-1 -: NO_WIDTH];
   assign out_res_o   = head[RES_WIDTH-1:0];
   assign level_o     = level;
   assign overflow_o  = overflow;
   assign drop_cnt_o  = drop_cnt;

`ifdef AMP_COLLECT_SEQ_CHECK_EN
   logic                 synced;
   logic [NO_WIDTH-1:0]  expected, rd_no;
   logic                 seq_err;
   logic [CNT_WIDTH-1:0] seq_cnt;

   assign rd_no = rd_data_i[W-1 -: NO_WIDTH];

   // Dropped beats are checked too: the sequence describes the amplifier, not the FIFO.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         synced   <= 1'b0;
         expected <= '0;
         seq_err  <= 1'b0;
         seq_cnt  <= '0;
      end else if (clr_i) begin
         synced   <= 1'b0;
         expected <= '0;
         seq_err  <= 1'b0;
         seq_cnt  <= '0;
      end else begin
         seq_err <= 1'b0;
         if (rd_val_i) begin
            synced   <= 1'b1;
            expected <= rd_no + 1'b1;
            if (synced && rd_no != expected) begin
               seq_err <= 1'b1;
               if (seq_cnt != '1) seq_cnt <= seq_cnt + 1'b1;
            end
         end
      end
   end

   assign seq_err_o     = seq_err;
   assign seq_err_cnt_o = seq_cnt;
`else
   assign seq_err_o     = 1'b0;
   assign seq_err_cnt_o = '0;
`endif

endmodule
